// File: rtl/mdio_master.sv
// mdio_master: Clause-22 MDIO management master.
// Turns single register write/read commands into MDC/MDIO frames made of an
// optional preamble, ST, OP, PHYAD, REGAD, TA and DATA, followed by one idle
// bit period. On a read, the PHY drives TA bit 2 and DATA back on mdio_i.
`timescale 1ns/1ps

module mdio_master #(
  parameter int CLK_DIV      = 10,
  parameter int PREAMBLE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  phy_add,
  input  logic [4:0]  reg_add,
  input  logic [15:0] wr_data,
  input  logic        wren,
  input  logic        rden,
  output logic        busy,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  output logic        rd_err,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  localparam logic [5:0] PRE_LAST = 6'((PREAMBLE_LEN > 0) ? PREAMBLE_LEN - 1 : 0);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_HDR  = 3'd2;
  localparam logic [2:0] S_TA   = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]       state;
  logic [DIV_W-1:0] div_cnt;
  logic             half;
  logic [5:0]       bit_cnt;
  logic [31:0]      tx_sr;
  logic [15:0]      rx_sr;
  logic             is_read;
  logic             ta_err;

  logic             tick;
  logic [31:0]      frame_word;

  // End of a half bit period, plus the post-preamble bits of the frame.
  // A read carries ones in its TA/DATA slots so mdio_o rests high while
  // the pad is released to the PHY.
  always_comb begin
    tick       = (div_cnt == DIV_MAX);
    frame_word = {2'b01, (wren ? 2'b01 : 2'b10), phy_add, reg_add,
                  (wren ? {2'b10, wr_data} : 18'h3FFFF)};
  end

  // Command accept, MDC generation, bit sequencing and read capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      div_cnt  <= '0;
      half     <= 1'b0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      is_read  <= 1'b0;
      ta_err   <= 1'b0;
      busy     <= 1'b0;
      mdc      <= 1'b0;
      mdio_o   <= 1'b1;
      mdio_oe  <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
      rd_err   <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      if (state == S_IDLE) begin
        if (wren || rden) begin
          is_read <= ~wren;
          busy    <= 1'b1;
          rd_err  <= 1'b0;
          ta_err  <= 1'b0;
          div_cnt <= '0;
          half    <= 1'b0;
          mdc     <= 1'b0;
          mdio_oe <= 1'b1;
          if (PREAMBLE_LEN > 0) begin
            state   <= S_PRE;
            bit_cnt <= PRE_LAST;
            mdio_o  <= 1'b1;
            tx_sr   <= frame_word;
          end else begin
            state   <= S_HDR;
            bit_cnt <= 6'd13;
            mdio_o  <= frame_word[31];
            tx_sr   <= {frame_word[30:0], 1'b0};
          end
        end
      end else if (!tick) begin
        div_cnt <= div_cnt + DIV_W'(1);
      end else begin
        div_cnt <= '0;
        half    <= ~half;
        if (!half) begin
          if (state != S_DONE) begin
            mdc <= 1'b1;
          end
          if (is_read && (state == S_TA) && (bit_cnt == 6'd0)) begin
            ta_err <= mdio_i;
          end
          if (is_read && (state == S_DATA)) begin
            rx_sr <= {rx_sr[14:0], mdio_i};
          end
        end else begin
          mdc <= 1'b0;
          case (state)
            S_PRE: begin
              if (bit_cnt == 6'd0) begin
                state   <= S_HDR;
                bit_cnt <= 6'd13;
                mdio_o  <= tx_sr[31];
                tx_sr   <= {tx_sr[30:0], 1'b0};
              end else begin
                bit_cnt <= bit_cnt - 6'd1;
                mdio_o  <= 1'b1;
              end
            end
            S_HDR: begin
              mdio_o <= tx_sr[31];
              tx_sr  <= {tx_sr[30:0], 1'b0};
              if (bit_cnt == 6'd0) begin
                state   <= S_TA;
                bit_cnt <= 6'd1;
                mdio_oe <= ~is_read;
              end else begin
                bit_cnt <= bit_cnt - 6'd1;
              end
            end
            S_TA: begin
              mdio_o <= tx_sr[31];
              tx_sr  <= {tx_sr[30:0], 1'b0};
              if (bit_cnt == 6'd0) begin
                state   <= S_DATA;
                bit_cnt <= 6'd15;
              end else begin
                bit_cnt <= bit_cnt - 6'd1;
              end
            end
            S_DATA: begin
              if (bit_cnt == 6'd0) begin
                state   <= S_DONE;
                mdio_o  <= 1'b1;
                mdio_oe <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt - 6'd1;
                mdio_o  <= tx_sr[31];
                tx_sr   <= {tx_sr[30:0], 1'b0};
              end
            end
            S_DONE: begin
              state <= S_IDLE;
              busy  <= 1'b0;
              if (is_read) begin
                rd_valid <= 1'b1;
                rd_data  <= rx_sr;
                rd_err   <= ta_err;
              end
            end
            default: begin
              state   <= S_IDLE;
              busy    <= 1'b0;
              mdio_o  <= 1'b1;
              mdio_oe <= 1'b0;
            end
          endcase
        end
      end
    end
  end

endmodule
